// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C register-write engine and the
// IMU read path.
//   state_t    : transaction FSM states
//   P0..P3     : quarter-bit phase codes within one bit slot
//   I2C_WR     : R/W bit value for a write
//   bus_levels : {scl, sda_o} levels for a given state/phase/data bit
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam logic I2C_WR = 1'b0;

    // Bus levels for one phase of a bit slot, returned as {scl, sda_o}.
    // SDA only moves while SCL is low, except the START fall (P2) and the
    // STOP rise (P2).
    function automatic logic [1:0] bus_levels(input state_t st,
                                              input logic [1:0] ph,
                                              input logic bit_v);
        logic [1:0] lv;
        lv = 2'b11;
        case (st)
            START: begin
                case (ph)
                    P2:      lv = 2'b10;
                    P3:      lv = 2'b00;
                    default: lv = 2'b11;
                endcase
            end
            SHIFT:   lv = {(ph == P1) || (ph == P2), bit_v};
            ACK:     lv = {(ph == P1) || (ph == P2), 1'b1};
            STOP: begin
                case (ph)
                    P0:      lv = 2'b00;
                    P1:      lv = 2'b10;
                    default: lv = 2'b11;
                endcase
            end
            default: lv = 2'b11;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: quarter-bit timebase for the I2C engine.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clr   : synchronous clear, holds counter and phase at zero
//   tick  : one-clk strobe on the last clk of each quarter bit
//   phase : current quarter-bit phase (P0..P3), advances after each tick
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST) && !clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_reg_write.sv
// i2c_reg_write: single-register I2C master write (START, {dev,W}, reg,
// data, STOP) with ACK check after every byte.
//   clk, rst          : system clock, asynchronous active-low reset
//   start             : request a transaction
//   dev_addr          : 7-bit slave address
//   reg_addr, wr_data : target register and the byte written to it
//   busy, done        : transaction status
//   ack_err           : some ACK slot read 1; held until the next accepted start
//   scl, sda_o        : registered bus levels (1 = released)
//   sda_in            : synchronised SDA pad level
//   fsm_state         : current FSM state, for observation only
//
// Handshake: start is sampled only while the FSM is IDLE. busy rises on the
// clk after acceptance and stays high through STOP. done is a single-clk
// pulse with busy=0, and start in that cycle is ignored.
module i2c_reg_write
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_o,
    input  logic       sda_in,
    output state_t     fsm_state
);

    state_t          state, state_nxt;
    logic [1:0]      byte_idx, byte_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [1:0]      ph_nxt;
    logic [0:2][7:0] frame;
    logic            tick, clr, slot_end;
    logic [1:0]      phase;

    assign fsm_state = state;

    // The timebase runs only while a transaction is on the bus, so every
    // transaction begins at quarter-count zero, phase P0.
    assign clr      = (state == IDLE) || (state == DONE);
    assign slot_end = tick && (phase == P3);

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .tick  (tick),
        .phase (phase)
    );

    always_comb begin
        state_nxt = state;
        byte_nxt  = byte_idx;
        bit_nxt   = bit_idx;
        ph_nxt    = tick ? phase + 2'd1 : phase;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = START;
                    byte_nxt  = 2'd0;
                    bit_nxt   = 3'd7;
                end
            end
            START: begin
                if (slot_end) begin
                    state_nxt = SHIFT;
                    byte_nxt  = 2'd0;
                    bit_nxt   = 3'd7;
                end
            end
            SHIFT: begin
                if (slot_end) begin
                    if (bit_idx == 3'd0) state_nxt = ACK;
                    else                 bit_nxt   = bit_idx - 3'd1;
                end
            end
            ACK: begin
                // ack_err already holds this slot's sample (taken in P1).
                if (slot_end) begin
                    if (ack_err || byte_idx == 2'd2) begin
                        state_nxt = STOP;
                    end else begin
                        state_nxt = SHIFT;
                        byte_nxt  = byte_idx + 2'd1;
                        bit_nxt   = 3'd7;
                    end
                end
            end
            STOP: begin
                if (slot_end) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state/phase so the bus levels
    // line up with the cycle in which that state/phase becomes current.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            bit_idx  <= 3'd0;
            frame    <= '0;
            scl      <= 1'b1;
            sda_o    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state          <= state_nxt;
            byte_idx       <= byte_nxt;
            bit_idx        <= bit_nxt;
            {scl, sda_o}   <= bus_levels(state_nxt, ph_nxt, frame[byte_nxt][bit_nxt]);
            busy           <= (state_nxt == START) || (state_nxt == SHIFT) ||
                              (state_nxt == ACK)   || (state_nxt == STOP);
            done           <= (state_nxt == DONE);
            if (state == IDLE && start) begin
                frame   <= {{dev_addr, I2C_WR}, reg_addr, wr_data};
                ack_err <= 1'b0;
            end else if (state == ACK && phase == P1 && tick && sda_in) begin
                ack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_write.sv
// tb_i2c_reg_write: bench for i2c_reg_write with CLK_DIV=4 and a slave model
// that ACKs address 7'h68 (and optionally NACKs the data byte).
module tb_i2c_reg_write;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy, done, ack_err, scl, sda_o, sda_in;
    state_t     fsm_state;

    logic pull = 1'b0;
    assign sda_in = sda_o & ~pull;

    i2c_reg_write #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda_o     (sda_o),
        .sda_in    (sda_in),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave / bus monitor ----------------
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         bitn = 0;
    int         byte_no = 0;
    bit         in_ack = 1'b0;
    logic [7:0] cur = '0;
    logic       nack_data = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (prev_scl && scl) begin
            // Any SDA change with SCL high is a START or STOP condition.
            if (prev_sda && !sda_in) begin
                start_cnt++;
                bitn = 0; in_ack = 1'b0; byte_no = 0; cur = '0;
            end else if (!prev_sda && sda_in) begin
                stop_cnt++;
            end
        end else if (!prev_scl && scl) begin
            if (!in_ack && bitn < 8) begin
                cur = {cur[6:0], sda_in};
                bitn++;
            end
        end else if (prev_scl && !scl) begin
            if (in_ack) begin
                pull = 1'b0; in_ack = 1'b0; bitn = 0; byte_no++;
            end else if (bitn == 8) begin
                got_q.push_back(cur);
                if (byte_no == 0)      pull = (cur[7:1] == 7'h68);
                else if (byte_no == 2) pull = !nack_data;
                else                   pull = 1'b1;
                in_ack = 1'b1;
            end
        end
        prev_scl = scl;
        prev_sda = sda_in;
    end

    // ---------------- scoreboard / reference model ----------------
    logic [7:0] exp_q[$];

    // Expected bytes on the wire: everything up to and including the first
    // NACKed byte. Duration: 4 START ticks + 36 per byte + 4 STOP ticks.
    function automatic logic model_err(input logic [6:0] d, input logic nd);
        return (d != 7'h68) || nd;
    endfunction

    function automatic int model_cycles(input logic [6:0] d);
        int nbytes;
        nbytes = (d == 7'h68) ? 3 : 1;
        return (4 + 36 * nbytes + 4) * CLK_DIV;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic run_txn(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                           input logic nd, input int poke_busy, input bit poke_done,
                           input logic exp_err, input int exp_cycles);
        int cyc;
        int extra;
        int n;
        wait_idle();
        exp_q = {};
        exp_q.push_back({d, 1'b0});
        if (d == 7'h68) begin exp_q.push_back(r); exp_q.push_back(w); end
        got_q = {};
        start_cnt = 0; stop_cnt = 0;
        nack_data = nd;

        @(negedge clk);
        dev_addr = d; reg_addr = r; wr_data = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom);
        check("busy_rise", busy, 1'b1);
        check("ack_err_clear", ack_err, 1'b0);

        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke_busy);
            if (cyc == poke_busy) begin
                dev_addr = 7'h68; reg_addr = ~r; wr_data = ~w;
            end
        end
        start = 1'b0;
        check("duration", cyc, exp_cycles);
        check("busy_at_done", busy, 1'b0);
        check("ack_err", ack_err, exp_err);

        if (poke_done) begin
            start = 1'b1; dev_addr = 7'h68;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_width", done, 1'b0);
        extra = 0;
        repeat (20) begin @(negedge clk); if (busy) extra++; end
        check("no_extra_txn", extra, 0);
        check("ack_err_hold", ack_err, exp_err);

        check("start_cond_count", start_cnt, 1);
        check("stop_cond_count", stop_cnt, 1);
        check("byte_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0] d;
        logic [7:0] r;
        logic [7:0] w;
        logic       nd;
        int         poke_busy;
        bit         poke_done;
        logic       exp_err;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{7'h68, 8'h1B, 8'h18, 1'b0, 0,  1'b0, 1'b0, 464};  // basic write
        vecs[1] = '{7'h0C, 8'h1B, 8'h18, 1'b0, 0,  1'b0, 1'b1, 176};  // wrong address
        vecs[2] = '{7'h68, 8'h1B, 8'h18, 1'b1, 0,  1'b0, 1'b1, 464};  // NACK on data
        vecs[3] = '{7'h68, 8'h10, 8'h08, 1'b0, 50, 1'b0, 1'b0, 464};  // start while busy
        vecs[4] = '{7'h68, 8'h6B, 8'h00, 1'b0, 0,  1'b1, 1'b0, 464};  // start in DONE cycle

        // reset state
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda_o, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_txn(vecs[i].d, vecs[i].r, vecs[i].w, vecs[i].nd, vecs[i].poke_busy,
                    vecs[i].poke_done, vecs[i].exp_err, vecs[i].exp_cycles);

        // random transactions against the reference model
        for (int i = 0; i < 6; i++) begin
            logic [6:0] d;
            logic [7:0] r, w;
            logic       nd;
            d  = ($urandom_range(0, 1) == 1) ? 7'h68 : 7'($urandom);
            r  = 8'($urandom);
            w  = 8'($urandom);
            nd = 1'($urandom_range(0, 1));
            run_txn(d, r, w, nd, 0, 1'b0, model_err(d, nd), model_cycles(d));
        end

        // reset in the middle of SHIFT
        wait_idle();
        nack_data = 1'b0;
        @(negedge clk);
        dev_addr = 7'h68; reg_addr = 8'h1B; wr_data = 8'h18; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_scl", scl, 1'b1);
        check("abort_sda", sda_o, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_state", fsm_state, IDLE);
        pull = 1'b0; in_ack = 1'b0; bitn = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(7'h68, 8'h1C, 8'h08, 1'b0, 0, 1'b0, 1'b0, 464);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
